// File: rtl/pong_pkg.sv
// Shared state encodings, screen codes and defaults for the pong game controller.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] SCR_MENU = 2'd0;
    localparam logic [1:0] SCR_GAME = 2'd1;
    localparam logic [1:0] SCR_OVER = 2'd2;

    localparam int unsigned WIN_SCORE_DEF    = 7;
    localparam int unsigned SERVE_FRAMES_DEF = 60;
    localparam int unsigned POINT_FRAMES_DEF = 90;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector: one-cycle pulse when din goes high; history clears in reset.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic prev_q, prev_d;

    always_comb prev_d = din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= 1'b0;
        else      prev_q <= prev_d;
    end

    // History of 0 at reset means a level already high at release yields a pulse.
    assign pulse = din & ~prev_q;

endmodule

// File: rtl/pong_game_fsm.sv
// Pong game sequencer: menu, serve delay, play, point pause and game-over screens,
// with score keeping and frame-based timing from vsync.
module pong_game_fsm
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int unsigned POINT_FRAMES = POINT_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       mouse_left,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic [1:0] screen_sel,
    output logic       ball_rst,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       winner
);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN_PTS    = 4'(WIN_SCORE);

    logic tick, start;

    rise_det u_vsync_det (.clk(clk), .rst(rst), .din(vsync_in),   .pulse(tick));
    rise_det u_mouse_det (.clk(clk), .rst(rst), .din(mouse_left), .pulse(start));

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic [1:0] screen_sel_q, screen_sel_d;
    logic       ball_rst_q, ball_rst_d;
    logic       ball_en_q, ball_en_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;

        case (state_q)
            ST_MENU: begin
                if (start) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    serve_dir_d = 1'b0;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_PLAY: begin
                if (miss_l && miss_r) begin
                    serve_dir_d = ~serve_dir_q;
                    state_d     = ST_POINT;
                end else if (miss_l) begin
                    score_r_d   = sat_inc(score_r_q);
                    serve_dir_d = 1'b0;
                    state_d     = ST_POINT;
                end else if (miss_r) begin
                    score_l_d   = sat_inc(score_l_q);
                    serve_dir_d = 1'b1;
                    state_d     = ST_POINT;
                end
            end
            ST_POINT: begin
                if (tick) begin
                    if (cnt_q == POINT_LAST) begin
                        if (score_l_q >= WIN_PTS || score_r_q >= WIN_PTS) begin
                            state_d  = ST_OVER;
                            winner_d = (score_r_q > score_l_q);
                        end else begin
                            state_d  = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_OVER: begin
                if (start) state_d = ST_MENU;
            end
            default: state_d = ST_MENU;
        endcase

        // Every state starts its frame count from zero; an exiting tick is not carried over.
        if (state_d != state_q) cnt_d = 8'd0;

        // Outputs are decoded from the next state so they register alongside it.
        case (state_d)
            ST_MENU:  screen_sel_d = SCR_MENU;
            ST_OVER:  screen_sel_d = SCR_OVER;
            default:  screen_sel_d = SCR_GAME;
        endcase
        ball_rst_d = (state_d == ST_MENU) || (state_d == ST_SERVE) || (state_d == ST_OVER);
        ball_en_d  = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_MENU;
            cnt_q        <= 8'd0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 1'b0;
            screen_sel_q <= SCR_MENU;
            ball_rst_q   <= 1'b1;
            ball_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            screen_sel_q <= screen_sel_d;
            ball_rst_q   <= ball_rst_d;
            ball_en_q    <= ball_en_d;
        end
    end

    assign screen_sel = screen_sel_q;
    assign ball_rst   = ball_rst_q;
    assign ball_en    = ball_en_q;
    assign serve_dir  = serve_dir_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Bench for pong_game_fsm: directed game walk-through plus random inputs, all checked
// every cycle against a behavioural game model.
module tb_pong_game_fsm;

    localparam int WIN = 7;
    localparam int SF  = 60;
    localparam int PF  = 90;

    localparam int P_MENU  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_POINT = 3;
    localparam int P_OVER  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync_in = 1'b0, mouse_left = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
    logic [1:0] screen_sel;
    logic       ball_rst, ball_en, serve_dir, winner;
    logic [3:0] score_l, score_r;

    int n_chk  = 0;
    int n_pass = 0;
    bit done   = 1'b0;

    pong_game_fsm dut (
        .clk(clk), .rst(rst), .vsync_in(vsync_in), .mouse_left(mouse_left),
        .miss_l(miss_l), .miss_r(miss_r), .screen_sel(screen_sel),
        .ball_rst(ball_rst), .ball_en(ball_en), .serve_dir(serve_dir),
        .score_l(score_l), .score_r(score_r), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural game model ----------------
    int m_ph, m_fc, m_sl, m_sr;
    bit m_dir, m_win, m_vs, m_ml;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= P_MENU; m_fc <= 0; m_sl <= 0; m_sr <= 0;
            m_dir <= 1'b0; m_win <= 1'b0; m_vs <= 1'b0; m_ml <= 1'b0;
        end else begin : upd
            bit tk, st, dir, win;
            int ph, fc, sl, sr;
            tk = vsync_in && !m_vs;
            st = mouse_left && !m_ml;
            ph = m_ph; fc = m_fc; sl = m_sl; sr = m_sr; dir = m_dir; win = m_win;
            if (ph == P_MENU && st) begin
                sl = 0; sr = 0; dir = 1'b0; ph = P_SERVE; fc = 0;
            end else if (ph == P_SERVE && tk) begin
                fc++;
                if (fc == SF) begin ph = P_PLAY; fc = 0; end
            end else if (ph == P_PLAY && (miss_l || miss_r)) begin
                if (miss_l && miss_r) dir = !dir;
                else if (miss_l) begin sr = (sr < 15) ? sr + 1 : 15; dir = 1'b0; end
                else begin sl = (sl < 15) ? sl + 1 : 15; dir = 1'b1; end
                ph = P_POINT; fc = 0;
            end else if (ph == P_POINT && tk) begin
                fc++;
                if (fc == PF) begin
                    fc = 0;
                    if (sl >= WIN || sr >= WIN) begin ph = P_OVER; win = (sr > sl); end
                    else ph = P_SERVE;
                end
            end else if (ph == P_OVER && st) begin
                ph = P_MENU;
            end
            m_ph <= ph; m_fc <= fc; m_sl <= sl; m_sr <= sr; m_dir <= dir; m_win <= win;
            m_vs <= vsync_in; m_ml <= mouse_left;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!done) begin
            chk("screen_sel", 32'(screen_sel), (m_ph == P_MENU) ? 0 : (m_ph == P_OVER) ? 2 : 1);
            chk("ball_rst", 32'(ball_rst),
                32'(m_ph == P_MENU || m_ph == P_SERVE || m_ph == P_OVER));
            chk("ball_en", 32'(ball_en), 32'(m_ph == P_PLAY));
            chk("serve_dir", 32'(serve_dir), 32'(m_dir));
            chk("scores", {24'd0, score_l, score_r}, {24'd0, 4'(m_sl), 4'(m_sr)});
            if (m_ph == P_OVER || !rst) chk("winner", 32'(winner), 32'(m_win));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        vsync_in   = 1'b1;
        miss_l     = ($urandom_range(0, 7) == 0);
        miss_r     = ($urandom_range(0, 7) == 0);
        mouse_left = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        vsync_in = 1'b0; miss_l = 1'b0; miss_r = 1'b0; mouse_left = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic miss(input bit l, input bit r);
        miss_l = l; miss_r = r;
        @(negedge clk);
        miss_l = 1'b0; miss_r = 1'b0;
    endtask

    task automatic click();
        mouse_left = 1'b1;
        @(negedge clk);
        mouse_left = 1'b0;
    endtask

    task automatic run_point(input bit l, input bit r);
        ticks(SF);
        miss(l, r);
        ticks(PF);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_screen", 32'(screen_sel), 0);
        chk("rst_ball_rst", 32'(ball_rst), 1);
        chk("rst_scores", {24'd0, score_l, score_r}, 0);
        rst = 1'b1;
        @(negedge clk);

        click();
        chk("start_screen", 32'(screen_sel), 1);
        chk("start_ball_rst", 32'(ball_rst), 1);
        chk("start_scores", {24'd0, score_l, score_r}, 0);

        ticks(SF - 1);
        chk("serve_59_ball_en", 32'(ball_en), 0);
        tick();
        chk("serve_60_ball_en", 32'(ball_en), 1);

        miss(1'b1, 1'b0);
        chk("missl_score_r", 32'(score_r), 1);
        chk("missl_dir", 32'(serve_dir), 0);
        chk("missl_ball_en", 32'(ball_en), 0);
        ticks(PF - 1);
        chk("point_89_ball_rst", 32'(ball_rst), 0);
        tick();
        chk("point_90_ball_rst", 32'(ball_rst), 1);
        chk("point_90_screen", 32'(screen_sel), 1);

        ticks(SF);
        miss(1'b1, 1'b1);
        chk("both_scores", {24'd0, score_l, score_r}, 32'h01);
        chk("both_dir", 32'(serve_dir), 1);
        chk("both_ball_en", 32'(ball_en), 0);
        ticks(PF);

        repeat (3) run_point(1'b0, 1'b1);
        repeat (4) run_point(1'b1, 1'b0);
        ticks(SF);
        chk("midplay_scores", {24'd0, score_l, score_r}, 32'h35);
        chk("midplay_ball_en", 32'(ball_en), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_screen", 32'(screen_sel), 0);
        chk("async_rst_scores", {24'd0, score_l, score_r}, 0);
        chk("async_rst_ball_en", 32'(ball_en), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        miss(1'b1, 1'b0);
        miss(1'b0, 1'b1);
        chk("menu_miss_scores", {24'd0, score_l, score_r}, 0);

        click();
        repeat (WIN) run_point(1'b1, 1'b0);
        chk("over_screen", 32'(screen_sel), 2);
        chk("over_winner", 32'(winner), 1);
        chk("over_score_r", 32'(score_r), 7);
        click();
        chk("over_click_screen", 32'(screen_sel), 0);

        // Button already held when reset lifts: the start must still be seen.
        mouse_left = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("release_start_screen", 32'(screen_sel), 1);
        mouse_left = 1'b0;

        for (int c = 0; c < 8000; c++) begin
            vsync_in   = ($urandom_range(0, 3) == 0);
            mouse_left = ($urandom_range(0, 149) == 0);
            miss_l     = ($urandom_range(0, 29) == 0);
            miss_r     = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
